// File: rtl/pong_pkg.sv
// Shared Pong constants: display geometry, goal lines, controller state and winner codes.
package pong_pkg;

    localparam int unsigned D_WIDTH     = 640;
    localparam int unsigned D_HEIGHT    = 480;
    localparam int unsigned GOAL_MARGIN = 10;
    localparam int unsigned GOAL_TOP_Y  = GOAL_MARGIN;
    localparam int unsigned GOAL_BOT_Y  = D_HEIGHT - GOAL_MARGIN;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_A    = 2'd1;
    localparam logic [1:0] WIN_B    = 2'd2;

    // Widen before adding so the top bit of the sum is kept.
    function automatic logic [11:0] ball_centre(input logic [11:0] y1, input logic [11:0] y2);
        logic [12:0] sum;
        sum = {1'b0, y1} + {1'b0, y2};
        return sum[12:1];
    endfunction

endpackage

// File: rtl/score_counter.sv
// Per-player score register: clear, increment, and saturation at the winning score.
module score_counter
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 9
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_score
);

    localparam logic [3:0] WIN_MAX = 4'(WIN_SCORE);

    logic [3:0] score_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            score_q <= 4'd0;
        end else if (i_inc && (score_q != WIN_MAX)) begin
            score_q <= score_q + 4'd1;
        end
    end

    assign o_score = score_q;

endmodule

// File: rtl/game_ctrl.sv
// Pong match controller: goal detection, scoring, post-goal freeze and game-over handling.
module game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALL_SIZE   = 10,
    parameter int unsigned GOAL_BOT    = GOAL_BOT_Y,
    parameter int unsigned GOAL_TOP    = GOAL_TOP_Y,
    parameter int unsigned HOLD_FRAMES = 60,
    parameter int unsigned WIN_SCORE   = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_start,
    input  logic [11:0] i_ball_y1,
    input  logic [11:0] i_ball_y2,
    output logic        o_animate,
    output logic        o_ball_rst,
    output logic [3:0]  o_score_a,
    output logic [3:0]  o_score_b,
    output logic [1:0]  o_state,
    output logic [1:0]  o_winner
);

    localparam logic [11:0] BOT_LINE  = 12'(GOAL_BOT);
    localparam logic [11:0] TOP_LINE  = 12'(GOAL_TOP);
    localparam logic [7:0]  HOLD_INIT = 8'(HOLD_FRAMES);
    localparam logic [3:0]  WIN_MAX   = 4'(WIN_SCORE);

    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
        $error("HOLD_FRAMES must be in 1..255");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
        $error("WIN_SCORE must be in 1..15");
    end
    if (BALL_SIZE == 0 || GOAL_TOP >= GOAL_BOT) begin : g_bad_geom
        $error("goal lines or ball size inconsistent");
    end

    logic [1:0]  state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [1:0]  winner_q, winner_d;
    logic        start_q;
    logic        animate_q;
    logic        ball_rst_q, ball_rst_d;
    logic        start_edge;
    logic        inc_a, inc_b, clr_scores;
    logic [11:0] yc;
    logic [3:0]  score_a, score_b;

    assign yc         = ball_centre(i_ball_y1, i_ball_y2);
    assign start_edge = i_start & ~start_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        winner_d   = winner_q;
        ball_rst_d = 1'b0;
        inc_a      = 1'b0;
        inc_b      = 1'b0;
        clr_scores = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr_scores = 1'b1;
                winner_d   = WIN_NONE;
                if (start_edge) begin
                    state_d    = ST_PLAY;
                    ball_rst_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (i_ani_stb) begin
                    if (yc >= BOT_LINE) begin
                        inc_b   = 1'b1;
                        state_d = ST_HOLD;
                        hold_d  = HOLD_INIT;
                    end else if (yc <= TOP_LINE) begin
                        inc_a   = 1'b1;
                        state_d = ST_HOLD;
                        hold_d  = HOLD_INIT;
                    end
                end
            end
            ST_HOLD: begin
                if (i_ani_stb) begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q == 8'd1) begin
                        if (score_a == WIN_MAX) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_A;
                        end else if (score_b == WIN_MAX) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_B;
                        end else begin
                            state_d    = ST_PLAY;
                            ball_rst_d = 1'b1;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    clr_scores = 1'b1;
                    winner_d   = WIN_NONE;
                    state_d    = ST_PLAY;
                    ball_rst_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // start_q tracks i_start even in reset so a button held through reset is not an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= 8'd0;
            winner_q   <= WIN_NONE;
            start_q    <= i_start;
            animate_q  <= 1'b0;
            ball_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            winner_q   <= winner_d;
            start_q    <= i_start;
            animate_q  <= (state_d == ST_PLAY);
            ball_rst_q <= ball_rst_d;
        end
    end

    score_counter #(
        .WIN_SCORE(WIN_SCORE)
    ) u_score_a (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (clr_scores),
        .i_inc  (inc_a),
        .o_score(score_a)
    );

    score_counter #(
        .WIN_SCORE(WIN_SCORE)
    ) u_score_b (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (clr_scores),
        .i_inc  (inc_b),
        .o_score(score_b)
    );

    assign o_animate  = animate_q;
    assign o_ball_rst = ball_rst_q;
    assign o_score_a  = score_a;
    assign o_score_b  = score_b;
    assign o_state    = state_q;
    assign o_winner   = winner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed vector table, corner sequences, random vs model.
module tb_game_ctrl;

    localparam int HOLD = 3;
    localparam int WIN  = 2;
    localparam int GBOT = 470;
    localparam int GTOP = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        start = 1'b0;
    logic [11:0] y1 = 12'd200;
    logic [11:0] y2 = 12'd220;
    logic        animate, ball_rst;
    logic [3:0]  score_a, score_b;
    logic [1:0]  state, winner;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .BALL_SIZE  (10),
        .GOAL_BOT   (GBOT),
        .GOAL_TOP   (GTOP),
        .HOLD_FRAMES(HOLD),
        .WIN_SCORE  (WIN)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ani_stb (stb),
        .i_start   (start),
        .i_ball_y1 (y1),
        .i_ball_y2 (y2),
        .o_animate (animate),
        .o_ball_rst(ball_rst),
        .o_score_a (score_a),
        .o_score_b (score_b),
        .o_state   (state),
        .o_winner  (winner)
    );

    typedef struct {
        logic rst, start, stb;
        int   y1, y2;
        int   st, sa, sb, anim, brst, win;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic b, input int a,
                                input int c, input int st, input int sa, input int sb,
                                input int an, input int br, input int w);
        vec_t v;
        v.rst = r; v.start = s; v.stb = b; v.y1 = a; v.y2 = c;
        v.st = st; v.sa = sa; v.sb = sb; v.anim = an; v.brst = br; v.win = w;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int sa, input int sb,
                           input int an, input int br, input int w);
        chk({tag, ".state"}, 32'(state), st);
        chk({tag, ".score_a"}, 32'(score_a), sa);
        chk({tag, ".score_b"}, 32'(score_b), sb);
        chk({tag, ".animate"}, 32'(animate), an);
        chk({tag, ".ball_rst"}, 32'(ball_rst), br);
        chk({tag, ".winner"}, 32'(winner), w);
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input int a, input int c);
        rst = r; start = s; stb = b; y1 = 12'(a); y2 = 12'(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame of freeze: an idle cycle then a strobe with a neutral ball.
    task automatic hold_frame();
        drive(0, 0, 0, 200, 220); cyc();
        drive(0, 0, 1, 200, 220); cyc();
    endtask

    // Reference model state, updated from the rule-level description of the match.
    int m_st, m_sa, m_sb, m_win, m_hold, m_anim, m_brst;
    logic m_prev_start;

    task automatic model_step(input logic r, input logic s, input logic b, input int a,
                              input int c);
        int yc;
        logic edge_seen;
        yc = (a + c) / 2;
        edge_seen = s && !m_prev_start;
        m_prev_start = s;
        m_brst = 0;
        if (r) begin
            m_st = 0; m_sa = 0; m_sb = 0; m_win = 0; m_hold = 0; m_anim = 0;
            return;
        end
        if (m_st == 0) begin
            if (edge_seen) begin m_st = 1; m_brst = 1; end
        end else if (m_st == 1) begin
            if (b && yc >= GBOT) begin
                m_sb = (m_sb < WIN) ? m_sb + 1 : WIN; m_st = 2; m_hold = HOLD;
            end else if (b && yc <= GTOP) begin
                m_sa = (m_sa < WIN) ? m_sa + 1 : WIN; m_st = 2; m_hold = HOLD;
            end
        end else if (m_st == 2) begin
            if (b) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin
                    if (m_sa == WIN) begin m_st = 3; m_win = 1; end
                    else if (m_sb == WIN) begin m_st = 3; m_win = 2; end
                    else begin m_st = 1; m_brst = 1; end
                end
            end
        end else begin
            if (edge_seen) begin
                m_sa = 0; m_sb = 0; m_win = 0; m_st = 1; m_brst = 1;
            end
        end
        m_anim = (m_st == 1) ? 1 : 0;
    endtask

    initial begin
        // rst start stb y1 y2 | state sa sb anim brst win
        vecs.push_back(mk(1, 0, 0, 200, 220, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 200, 220, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 200, 220, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 200, 220, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 200, 220, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 460, 480, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 460, 480, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 459, 479, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 460, 480, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 460, 480, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 200, 220, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 200, 220, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 200, 220, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 460, 480, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 200, 220, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 200, 220, 1, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 22, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 22, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 20, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 20, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 20, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 200, 220, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 200, 220, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 200, 220, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 200, 220, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 200, 220, 2, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 200, 220, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 200, 220, 1, 1, 1, 1, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stb, vecs[i].y1, vecs[i].y2);
            cyc();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].sa, vecs[i].sb,
                    vecs[i].anim, vecs[i].brst, vecs[i].win);
        end

        // Match win: two B goals end the match, start edge begins a fresh one.
        drive(1, 0, 0, 200, 220); cyc();
        drive(0, 1, 0, 200, 220); cyc();
        chk_all("win.start", 1, 0, 0, 1, 1, 0);
        drive(0, 0, 1, 460, 480); cyc();
        chk_all("win.goal1", 2, 0, 1, 0, 0, 0);
        for (int i = 0; i < HOLD; i++) hold_frame();
        chk_all("win.resume", 1, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 200, 220); cyc();
        drive(0, 0, 1, 470, 490); cyc();
        chk_all("win.goal2", 2, 0, 2, 0, 0, 0);
        for (int i = 0; i < HOLD; i++) hold_frame();
        chk_all("win.over", 3, 0, 2, 0, 0, 2);
        drive(0, 0, 0, 200, 220); cyc();
        drive(0, 0, 1, 460, 480); cyc();
        chk_all("win.over_stb", 3, 0, 2, 0, 0, 2);
        drive(0, 1, 0, 200, 220); cyc();
        chk_all("win.restart", 1, 0, 0, 1, 1, 0);

        // Reset mid-HOLD with start held high through and after reset.
        drive(0, 0, 0, 200, 220); cyc();
        drive(0, 0, 1, 0, 20); cyc();
        chk_all("rh.goal", 2, 1, 0, 0, 0, 0);
        hold_frame();
        drive(1, 1, 0, 200, 220); cyc();
        chk_all("rh.reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 200, 220); cyc();
            chk_all($sformatf("rh.held%0d", i), 0, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 200, 220); cyc();
        chk_all("rh.drop", 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 200, 220); cyc();
        chk_all("rh.rise", 1, 0, 0, 1, 1, 0);

        // Random stimulus against the reference model.
        begin
            logic r, s, b;
            int a, c, since;
            s = 1'b0;
            since = 0;
            m_prev_start = 1'b0;
            for (int n = 0; n < 4000; n++) begin
                r = (n == 0) || ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 9) == 0) s = ~s;
                b = (since >= 1) && ($urandom_range(0, 2) == 0);
                since = b ? 0 : since + 1;
                case ($urandom_range(0, 4))
                    0: begin a = $urandom_range(460, 510); c = a + 20; end
                    1: begin a = $urandom_range(0, 10); c = $urandom_range(0, 10); end
                    2: begin a = $urandom_range(465, 475); c = $urandom_range(465, 475); end
                    3: begin a = $urandom_range(0, 4095); c = $urandom_range(0, 4095); end
                    default: begin a = $urandom_range(100, 400); c = a + 20; end
                endcase
                drive(r, s, b, a, c);
                model_step(r, s, b, a, c);
                cyc();
                chk_all($sformatf("rnd%0d", n), m_st, m_sa, m_sb, m_anim, m_brst, m_win);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
